// File: rtl/image_buffer_reader_if.sv
// Shared line types and the output stream interface of image_buffer_reader.
//   image_buffer_reader_pkg : complex_fxp_t sample and line_t (2 x 16 samples)
//   image_buffer_reader_if  : out_data / out_valid / out_ready stream
//     master modport - producer (drives data/valid, samples ready)
//     slave modport  - consumer (samples data/valid, drives ready)

package image_buffer_reader_pkg;

    localparam int unsigned FXP_WIDTH = 16;
    localparam int unsigned LINE_ROWS = 2;
    localparam int unsigned LINE_COLS = 16;

    // One fixed-point complex sample.
    typedef struct packed {
        logic signed [FXP_WIDTH-1:0] re;
        logic signed [FXP_WIDTH-1:0] im;
    } complex_fxp_t;

    // One image-buffer line as delivered by the bank.
    typedef complex_fxp_t [0:LINE_ROWS-1][0:LINE_COLS-1] line_t;

endpackage

interface image_buffer_reader_if;

    image_buffer_reader_pkg::line_t out_data;
    logic                           out_valid;
    logic                           out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/image_buffer_reader.sv
// Streams a block of consecutive lines out of an image_buffer_bank.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start                   : one-cycle request, accepted only when idle
//   base_addr, num_lines    : first line and line count, sampled with start
//   read_address            : bank read address (held when no read is issued)
//   mem_data                : bank data, valid one cycle after its address
//   ob (master)             : out_data / out_valid / out_ready line stream
//   busy, done              : transfer in progress, one-cycle completion pulse
// read_address is decoded from registered state and this cycle's handshake so
// that a read can be issued in the same cycle a beat leaves; this is what lets
// a two-entry FIFO sustain one beat per cycle with a one-cycle bank.

module image_buffer_reader #(
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            num_lines,
    output logic [ADDR_WIDTH-1:0]          read_address,
    input  image_buffer_reader_pkg::line_t mem_data,
    image_buffer_reader_if.master          ob,
    output logic                           busy,
    output logic                           done
);

    import image_buffer_reader_pkg::line_t;

    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam int unsigned OCC_WIDTH  = 3;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] next_addr_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [CNT_WIDTH-1:0]  remaining_q;
    logic                  in_flight_q;
    logic [1:0]            count_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    line_t                 fifo_q [FIFO_DEPTH];
    logic                  busy_q;
    logic                  done_q;

    logic                  pop_c;
    logic                  issue_c;
    logic                  done_d;
    logic                  accept_c;
    logic [OCC_WIDTH-1:0]  occupancy_c;

    assign pop_c       = ob.out_valid && ob.out_ready;
    assign occupancy_c = OCC_WIDTH'(count_q) + OCC_WIDTH'(in_flight_q);
    assign accept_c    = (state_q == IDLE) && start && (num_lines != '0);

    // Next-state, read issue and completion decode.
    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_lines == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Only issue if the line is guaranteed a FIFO slot when it lands.
                if (occupancy_c <= OCC_WIDTH'(pop_c) + OCC_WIDTH'(1)) begin
                    issue_c = 1'b1;
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Final beat: the only buffered line leaves and nothing is in flight.
                if (pop_c && (count_q == 2'd1) && !in_flight_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, address generation and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            last_addr_q <= '0;
            remaining_q <= '0;
            in_flight_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= done_d;
            in_flight_q <= issue_c;
            if (accept_c) begin
                next_addr_q <= base_addr;
                remaining_q <= num_lines;
            end else if (issue_c) begin
                next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
                last_addr_q <= next_addr_q;
                remaining_q <= remaining_q - CNT_WIDTH'(1);
            end
            if (in_flight_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(in_flight_q) - 2'(pop_c);
        end
    end

    // Line storage; contents are only observable while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (in_flight_q) begin
            fifo_q[wr_ptr_q] <= mem_data;
        end
    end

    assign read_address = issue_c ? next_addr_q : last_addr_q;
    assign ob.out_valid = (count_q != '0);
    assign ob.out_data  = (count_q != '0) ? fifo_q[rd_ptr_q] : '0;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_image_buffer_reader.sv
// Randomised scoreboard bench for image_buffer_reader with a behavioural bank.
module tb_image_buffer_reader;

    import image_buffer_reader_pkg::*;

    localparam int unsigned AW    = 11;
    localparam int          DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_lines;
    logic [AW-1:0] read_address;
    line_t         mem_data;
    logic          busy;
    logic          done;

    image_buffer_reader_if ob_if();

    image_buffer_reader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_lines    (num_lines),
        .read_address (read_address),
        .mem_data     (mem_data),
        .ob           (ob_if),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    line_t mem [DEPTH];
    line_t exp_q [$];
    int    n_tests    = 0;
    int    n_fail     = 0;
    int    beats      = 0;
    int    ready_mode = 0;
    int    cyc        = 0;

    // Behavioural bank: one-cycle registered read.
    always @(posedge clk) mem_data <= mem[read_address];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // Consumer: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        ob_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       ob_if.out_ready = 1'b1;
                1:       ob_if.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: ob_if.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    logic         prev_stall = 1'b0;
    line_t        prev_data;
    line_t        mon_exp;
    logic [1023:0] mon_got_v;
    logic [1023:0] mon_exp_v;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_tests++;
                    if (!ob_if.out_valid || (ob_if.out_data !== prev_data)) begin
                        n_fail++;
                        $display("FAIL stall_hold valid=%0b data_changed=%0b @%0t",
                                 ob_if.out_valid, ob_if.out_data !== prev_data, $time);
                    end
                end
                if (ob_if.out_valid && ob_if.out_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat got a beat, expected none @%0t", $time);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (ob_if.out_data !== mon_exp) begin
                            n_fail++;
                            mon_got_v = ob_if.out_data;
                            mon_exp_v = mon_exp;
                            $display("FAIL beat_data idx=%0d got_lo=%h exp_lo=%h @%0t",
                                     beats, mon_got_v[63:0], mon_exp_v[63:0], $time);
                        end
                    end
                    beats++;
                end
                prev_stall = ob_if.out_valid && !ob_if.out_ready;
                prev_data  = ob_if.out_data;
            end
        end
    end

    // Issues one transfer from between edges and returns in the done cycle.
    task automatic run_xfer(input int base, input int n, input bit chk_addr);
        bit finished;
        start     = 1'b1;
        base_addr = AW'(base);
        num_lines = (AW+1)'(n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        num_lines = (AW+1)'($urandom);
        finished  = 1'b0;
        for (int i = 0; i < 10000 && !finished; i++) begin
            @(negedge clk);
            if (n == 0) begin
                check("zero_done", 64'(done), 64'(1));
                check("zero_busy", 64'(busy), 64'(0));
                check("zero_valid", 64'(ob_if.out_valid), 64'(0));
                finished = 1'b1;
            end else begin
                if (i == 0) check("busy_after_start", 64'(busy), 64'(1));
                if (i < 2)  check("early_valid", 64'(ob_if.out_valid), 64'(0));
                if (i == 2) check("first_valid", 64'(ob_if.out_valid), 64'(1));
                if (chk_addr && i < n)
                    check("read_address", 64'(read_address), 64'((base + i) % DEPTH));
                if (done) begin
                    finished = 1'b1;
                    check("done_busy_low", 64'(busy), 64'(0));
                    check("queue_drained", 64'(exp_q.size()), 64'(0));
                end
            end
        end
        if (!finished) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_timeout base=%0d n=%0d", base, n);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [1023:0] fill;
        int b0;
        int base;
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_lines  = '0;
        ready_mode = 0;
        for (int a = 0; a < DEPTH; a++) begin
            for (int w = 0; w < 32; w++) fill[w*32 +: 32] = $urandom;
            mem[a] = line_t'(fill);
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_read_address", 64'(read_address), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_valid", 64'(ob_if.out_valid), 64'(0));
        check("rst_data_zero", 64'(ob_if.out_data == '0), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic, wrapping, stalled, zero-length and back-to-back transfers.
        run_xfer(5, 4, 1'b1);
        run_xfer(2046, 4, 1'b1);
        ready_mode = 1;
        run_xfer(100, 8, 1'b0);
        run_xfer(7, 0, 1'b0);
        run_xfer(9, 3, 1'b0);

        // Start pulsed mid-transfer must be ignored.
        ready_mode = 0;
        @(negedge clk);
        fork
            run_xfer(300, 6, 1'b1);
            begin
                repeat (3) @(negedge clk);
                start     = 1'b1;
                base_addr = AW'(900);
                num_lines = (AW+1)'(5);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join

        // Reset after the third beat of a ten-line transfer.
        @(negedge clk);
        b0        = beats;
        start     = 1'b1;
        base_addr = AW'(50);
        num_lines = (AW+1)'(10);
        for (int i = 0; i < 10; i++) exp_q.push_back(mem[50 + i]);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 100 && beats < b0 + 3; i++) @(posedge clk);
        check("third_beat_seen", 64'(beats - b0), 64'(3));
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_valid", 64'(ob_if.out_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_read_address", 64'(read_address), 64'(0));
        check("midrst_data_zero", 64'(ob_if.out_data == '0), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_quiet", 64'(ob_if.out_valid || busy), 64'(0));
        end
        run_xfer(0, 2, 1'b1);

        // Randomised transfers, including a full-depth one and a wrap.
        for (int k = 0; k < 24; k++) begin
            ready_mode = $urandom_range(0, 2);
            base       = $urandom_range(0, DEPTH - 1);
            n          = $urandom_range(0, 12);
            if (k == 5) begin
                ready_mode = 0;
                n          = DEPTH;
            end
            if (k == 6) begin
                base = DEPTH - 8;
                n    = 20;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_xfer(base, n, ready_mode == 0);
        end

        repeat (4) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_buffer_reader.md
IMAGE_BUFFER_READER -- requirements
Module: image_buffer_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, giving the line-address width of the attached image_buffer_bank.
REQ-002 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to stream a block of lines.
REQ-005 SHALL have port base_addr, input, ADDR_WIDTH bits: first line address, sampled with start.
REQ-006 SHALL have port num_lines, input, ADDR_WIDTH+1 bits: line count (0..2^ADDR_WIDTH), sampled with start.
REQ-007 SHALL have port read_address, output, ADDR_WIDTH bits: drives the bank read_address.
REQ-008 SHALL have port mem_data, input, complex_fxp_t [0:1][0:15]: bank data_out, valid one cycle after the address.
REQ-009 SHALL have port out_data, output, complex_fxp_t [0:1][0:15]: streamed line.
REQ-010 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): transfer occurs on a rising edge with both high.
REQ-011 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start with num_lines>0; RUN->DRAIN after the last read is issued; DRAIN->IDLE after the last beat transfers.
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored with no effect on the running transfer.
REQ-015 SHALL, on start with num_lines==0, stay IDLE, emit no beats, and pulse done in the next cycle with busy remaining low.
REQ-016 SHALL generate addresses base_addr, base_addr+1, ... modulo 2^ADDR_WIDTH (wrap from 2^ADDR_WIDTH-1 to 0).
REQ-017 SHALL issue at most one read per cycle and exactly num_lines reads per transfer.
REQ-018 SHALL model the bank read latency as exactly one cycle: data for an address driven in cycle T is captured from mem_data at the end of cycle T+1.
REQ-019 SHALL buffer captured lines in a 2-entry output FIFO, in issue order, with no loss or duplication.
REQ-020 SHALL issue a read in a cycle only if fifo_count + in_flight - (out_valid && out_ready) <= 1.
REQ-021 SHALL hold read_address at its last value when no read is issued.
REQ-022 SHALL sustain one beat per cycle while out_ready stays high.
REQ-023 SHALL present the first out_valid two cycles after the start-accepting edge (start sampled at edge E0 -> out_valid high after edge E2).
REQ-024 SHALL keep out_data stable and out_valid high while out_valid && !out_ready.
REQ-025 SHALL pulse done, and drop busy, in the cycle after the final beat transfers.
REQ-026 SHALL accept a new start in the same cycle done is high.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE, FIFO empty, in_flight 0, out_valid 0, busy 0, done 0, read_address 0, out_data 0.
REQ-028 SHALL, on reset mid-transfer, discard all buffered and in-flight data and emit no further beats until a new start.

Verification
REQ-029 Scenario: base_addr=5, num_lines=4, out_ready=1 -> read_address 5,6,7,8 on consecutive cycles; beats equal to bank lines 5..8 on four consecutive cycles starting two cycles after start; done once.
REQ-030 Scenario: base_addr=2046, num_lines=4 (ADDR_WIDTH=11) -> addresses 2046,2047,0,1; data order preserved.
REQ-031 Scenario: num_lines=8, out_ready toggling 1,0,0,1 repeating -> exactly 8 beats in order; out_data stable across stall cycles; no more than 2 lines buffered.
REQ-032 Scenario: start with num_lines=0 -> done high one cycle later; out_valid and busy never high.
REQ-033 Scenario: rst_n low for one cycle after the 3rd beat of a 10-line transfer -> outputs at reset values immediately; no further beats; new start with base_addr=0, num_lines=2 completes normally.
REQ-034 Scenario: start pulsed again mid-transfer with different base_addr -> ignored; original transfer completes unchanged.
